mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port `Memory` between the instruction-fetch path (read-only) and the load/store path (read/write). It accepts one command at a time using a start/ready handshake and forwards it unchanged to the memory port. It waits out the memory's registered read latency and returns read data to the requester that issued the read. It sits between the core's fetch and memory stages and the `Memory` instance.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Fetch, load/store and memory-port signals of mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        i_cmd_start;
    logic        i_cmd_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;

    logic        d_cmd_start;
    logic        d_cmd_write;
    logic        d_cmd_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;

    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    // Arbiter side: accepts requests, drives the memory port.
    modport slave (
        input  i_cmd_start, i_addr,
        input  d_cmd_start, d_cmd_write, d_addr, d_wdata,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
        output i_cmd_ready, i_rdata, i_rdata_valid,
        output d_cmd_ready, d_rdata, d_rdata_valid,
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata
    );

    // Environment side: requesters and memory.
    modport master (
        output i_cmd_start, i_addr,
        output d_cmd_start, d_cmd_write, d_addr, d_wdata,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid,
        input  i_cmd_ready, i_rdata, i_rdata_valid,
        input  d_cmd_ready, d_rdata, d_rdata_valid,
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one memory port between fetch and
//            load/store; returns read data to the issuing requester.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);
    localparam logic c_SEL_I = 1'b0;
    localparam logic c_SEL_D = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_rdata_valid;
    logic        r_d_rdata_valid;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_mem_start;
    logic        w_mem_write;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_capture;

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_mem_start  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = 32'd0;
        w_mem_wdata  = 32'd0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so nothing reaches memory during the reset cycle.
                if (!rst && bus.mem_cmd_ready) begin
                    if (bus.d_cmd_start && (!bus.i_cmd_start || r_last_grant == c_SEL_I))
                        w_grant_d = 1'b1;
                    else if (bus.i_cmd_start)
                        w_grant_i = 1'b1;
                end
                if (w_grant_d) begin
                    w_mem_start = 1'b1;
                    w_mem_write = bus.d_cmd_write;
                    w_mem_addr  = bus.d_addr;
                    w_mem_wdata = bus.d_wdata;
                    if (!bus.d_cmd_write)
                        w_next_state = WAIT;
                end else if (w_grant_i) begin
                    w_mem_start  = 1'b1;
                    w_mem_addr   = bus.i_addr;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rdata_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_last_grant    <= c_SEL_I;
            r_owner         <= c_SEL_I;
            r_i_rdata       <= 32'd0;
            r_d_rdata       <= 32'd0;
            r_i_rdata_valid <= 1'b0;
            r_d_rdata_valid <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_i_rdata_valid <= 1'b0;
            r_d_rdata_valid <= 1'b0;
            if (w_grant_i) begin
                r_last_grant <= c_SEL_I;
                r_owner      <= c_SEL_I;
            end else if (w_grant_d) begin
                r_last_grant <= c_SEL_D;
                r_owner      <= c_SEL_D;
            end
            if (w_capture) begin
                if (r_owner == c_SEL_D) begin
                    r_d_rdata       <= bus.mem_rdata;
                    r_d_rdata_valid <= 1'b1;
                end else begin
                    r_i_rdata       <= bus.mem_rdata;
                    r_i_rdata_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.i_cmd_ready   = w_grant_i;
    assign bus.d_cmd_ready   = w_grant_d;
    assign bus.mem_cmd_start = w_mem_start;
    assign bus.mem_cmd_write = w_mem_write;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_wdata     = w_mem_wdata;
    assign bus.i_rdata       = r_i_rdata;
    assign bus.i_rdata_valid = r_i_rdata_valid;
    assign bus.d_rdata       = r_d_rdata;
    assign bus.d_rdata_valid = r_d_rdata_valid;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a small
//            registered-read memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 16 words, one-cycle registered read.
    logic [31:0] mem [0:15];
    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 32'd0;
    end

    always @(posedge clk) begin
        bus.mem_rdata_valid <= 1'b0;
        if (bus.mem_cmd_start && bus.mem_cmd_ready) begin
            if (bus.mem_cmd_write)
                mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            else begin
                bus.mem_rdata       <= mem[bus.mem_addr[5:2]];
                bus.mem_rdata_valid <= 1'b1;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_cmd_start   = 1'b0;
        bus.d_cmd_start   = 1'b0;
        bus.d_cmd_write   = 1'b0;
        bus.mem_cmd_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_cmd_start   = 1'b1;
        bus.i_addr        = 32'h0;
        bus.d_cmd_start   = 1'b1;
        bus.d_cmd_write   = 1'b0;
        bus.d_addr        = 32'h4;
        bus.mem_cmd_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.i_cmd_ready !== 1'b0 || bus.d_cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got i=%b d=%b exp 0 0", bus.i_cmd_ready, bus.d_cmd_ready);
        end
        checks++;
        if (bus.mem_cmd_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_start got=%b exp=0", bus.mem_cmd_start);
        end
        checks++;
        if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got i=%h d=%h exp 0 0", bus.i_rdata, bus.d_rdata);
        end
        checks++;
        if (bus.i_rdata_valid !== 1'b0 || bus.d_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got i=%b d=%b exp 0 0", bus.i_rdata_valid, bus.d_rdata_valid);
        end
        bus.i_cmd_start = 1'b0;
        bus.d_cmd_start = 1'b0;
    endtask

    task automatic test_write_read();
        apply_reset();
        @(negedge clk);  // cycle 0: write
        bus.d_cmd_start = 1'b1;
        bus.d_cmd_write = 1'b1;
        bus.d_addr      = 32'h10;
        bus.d_wdata     = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.d_cmd_ready !== 1'b1 || bus.mem_cmd_start !== 1'b1 || bus.mem_cmd_write !== 1'b1) begin
            failures++;
            $display("FAIL wr_accept got ready=%b start=%b write=%b exp 1 1 1",
                     bus.d_cmd_ready, bus.mem_cmd_start, bus.mem_cmd_write);
        end
        checks++;
        if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_pass got addr=%h wdata=%h exp 10 deadbeef", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);  // cycle 1: read
        bus.d_cmd_write = 1'b0;
        #1;
        checks++;
        if (bus.d_cmd_ready !== 1'b1 || bus.mem_cmd_write !== 1'b0) begin
            failures++;
            $display("FAIL rd_accept got ready=%b write=%b exp 1 0", bus.d_cmd_ready, bus.mem_cmd_write);
        end
        @(negedge clk);  // cycle 2: WAIT
        bus.d_cmd_start = 1'b0;
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b0 || bus.mem_cmd_start !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait got valid=%b start=%b exp 0 0", bus.d_rdata_valid, bus.mem_cmd_start);
        end
        @(negedge clk);  // cycle 3: response
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_resp got valid=%b data=%h exp 1 deadbeef", bus.d_rdata_valid, bus.d_rdata);
        end
        checks++;
        if (bus.i_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_resp_ivalid got=%b exp=0", bus.i_rdata_valid);
        end
        @(negedge clk);  // cycle 4: pulse over
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_pulse_width got=%b exp=0", bus.d_rdata_valid);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        @(negedge clk);
        bus.d_cmd_start = 1'b1;
        bus.d_cmd_write = 1'b1;
        bus.d_addr      = 32'h0;
        bus.d_wdata     = 32'h11111111;
        @(negedge clk);
        bus.d_addr      = 32'h4;
        bus.d_wdata     = 32'h22222222;
        apply_reset();   // last_grant back to I
        @(negedge clk);  // cycle 0
        bus.i_cmd_start = 1'b1;
        bus.i_addr      = 32'h0;
        bus.d_cmd_start = 1'b1;
        bus.d_cmd_write = 1'b0;
        bus.d_addr      = 32'h4;
        #1;
        checks++;
        if (bus.d_cmd_ready !== 1'b1 || bus.i_cmd_ready !== 1'b0 || bus.mem_addr !== 32'h4) begin
            failures++;
            $display("FAIL sim_c0 got d=%b i=%b addr=%h exp 1 0 4", bus.d_cmd_ready, bus.i_cmd_ready, bus.mem_addr);
        end
        @(negedge clk);  // cycle 1
        bus.d_cmd_start = 1'b0;
        #1;
        checks++;
        if (bus.d_cmd_ready !== 1'b0 || bus.i_cmd_ready !== 1'b0 || bus.mem_cmd_start !== 1'b0) begin
            failures++;
            $display("FAIL sim_c1 got d=%b i=%b start=%b exp 0 0 0",
                     bus.d_cmd_ready, bus.i_cmd_ready, bus.mem_cmd_start);
        end
        @(negedge clk);  // cycle 2
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b1 || bus.d_rdata !== 32'h22222222) begin
            failures++;
            $display("FAIL sim_d_resp got valid=%b data=%h exp 1 22222222", bus.d_rdata_valid, bus.d_rdata);
        end
        checks++;
        if (bus.i_cmd_ready !== 1'b1 || bus.mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL sim_i_grant got ready=%b addr=%h exp 1 0", bus.i_cmd_ready, bus.mem_addr);
        end
        @(negedge clk);  // cycle 3
        bus.i_cmd_start = 1'b0;
        @(negedge clk);  // cycle 4
        #1;
        checks++;
        if (bus.i_rdata_valid !== 1'b1 || bus.i_rdata !== 32'h11111111 || bus.d_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL sim_i_resp got valid=%b data=%h dvalid=%b exp 1 11111111 0",
                     bus.i_rdata_valid, bus.i_rdata, bus.d_rdata_valid);
        end
    endtask

    task automatic test_round_robin();
        int n_i;
        int n_d;
        n_i = 0;
        n_d = 0;
        apply_reset();
        @(negedge clk);
        bus.i_cmd_start = 1'b1;
        bus.i_addr      = 32'h0;
        bus.d_cmd_start = 1'b1;
        bus.d_cmd_write = 1'b0;
        bus.d_addr      = 32'h4;
        for (int c = 0; c < 16; c++) begin
            logic exp_d;
            logic exp_i;
            exp_d = ((c % 4) == 0);
            exp_i = ((c % 4) == 2);
            #1;
            checks++;
            if (bus.d_cmd_ready !== exp_d || bus.i_cmd_ready !== exp_i) begin
                failures++;
                $display("FAIL rr_cycle%0d got d=%b i=%b exp d=%b i=%b",
                         c, bus.d_cmd_ready, bus.i_cmd_ready, exp_d, exp_i);
            end
            if (bus.d_cmd_ready === 1'b1) n_d++;
            if (bus.i_cmd_ready === 1'b1) n_i++;
            @(negedge clk);
        end
        bus.i_cmd_start = 1'b0;
        bus.d_cmd_start = 1'b0;
        checks++;
        if (n_d != 4 || n_i != 4) begin
            failures++;
            $display("FAIL rr_counts got d=%0d i=%0d exp 4 4", n_d, n_i);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        bus.mem_cmd_ready = 1'b0;
        bus.d_cmd_write   = 1'b0;
        bus.d_addr        = 32'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.d_cmd_start = 1'b1;
            #1;
            checks++;
            if (bus.d_cmd_ready !== 1'b0 || bus.mem_cmd_start !== 1'b0) begin
                failures++;
                $display("FAIL stall_c%0d got ready=%b start=%b exp 0 0", c, bus.d_cmd_ready, bus.mem_cmd_start);
            end
        end
        @(negedge clk);  // cycle 3
        bus.mem_cmd_ready = 1'b1;
        #1;
        checks++;
        if (bus.d_cmd_ready !== 1'b1 || bus.mem_cmd_start !== 1'b1) begin
            failures++;
            $display("FAIL stall_grant got ready=%b start=%b exp 1 1", bus.d_cmd_ready, bus.mem_cmd_start);
        end
        @(negedge clk);
        bus.d_cmd_start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL stall_resp got valid=%b data=%h exp 1 deadbeef", bus.d_rdata_valid, bus.d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.d_cmd_start = 1'b1;
            bus.d_cmd_write = 1'b1;
            bus.d_addr      = 32'(4 * k);
            bus.d_wdata     = 32'(k + 1);
            #1;
            checks++;
            if (bus.d_cmd_ready !== 1'b1 || bus.mem_wdata !== 32'(k + 1)) begin
                failures++;
                $display("FAIL b2b_wr%0d got ready=%b wdata=%h exp 1 %h", k, bus.d_cmd_ready, bus.mem_wdata, k + 1);
            end
        end
        @(negedge clk);
        bus.d_cmd_start = 1'b0;
        bus.d_cmd_write = 1'b0;
        #1;
        checks++;
        if (bus.d_rdata_valid !== 1'b0 || bus.i_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_valid got d=%b i=%b exp 0 0", bus.d_rdata_valid, bus.i_rdata_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.d_cmd_start = 1'b1;
            bus.d_addr      = 32'(4 * k);
            @(negedge clk);
            bus.d_cmd_start = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (bus.d_rdata_valid !== 1'b1 || bus.d_rdata !== 32'(k + 1)) begin
                failures++;
                $display("FAIL b2b_rd%0d got valid=%b data=%h exp 1 %h", k, bus.d_rdata_valid, bus.d_rdata, k + 1);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        // Leave a non-zero word in i_rdata first (mem[0] = 1).
        @(negedge clk);
        bus.i_cmd_start = 1'b1;
        bus.i_addr      = 32'h0;
        @(negedge clk);
        bus.i_cmd_start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.i_rdata_valid !== 1'b1 || bus.i_rdata !== 32'h1) begin
            failures++;
            $display("FAIL mid_pre got valid=%b data=%h exp 1 1", bus.i_rdata_valid, bus.i_rdata);
        end
        @(negedge clk);  // cycle 0
        bus.i_cmd_start = 1'b1;
        bus.i_addr      = 32'h8;
        #1;
        checks++;
        if (bus.i_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_grant got=%b exp=1", bus.i_cmd_ready);
        end
        @(negedge clk);  // cycle 1
        bus.i_cmd_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);  // cycle 2
        rst = 1'b0;
        bus.i_cmd_start = 1'b1;
        #1;
        checks++;
        if (bus.i_rdata_valid !== 1'b0 || bus.i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_abandon got valid=%b data=%h exp 0 0", bus.i_rdata_valid, bus.i_rdata);
        end
        checks++;
        if (bus.i_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_idle got ready=%b exp=1", bus.i_cmd_ready);
        end
        @(negedge clk);  // cycle 3
        bus.i_cmd_start = 1'b0;
        #1;
        checks++;
        if (bus.i_rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_wait got valid=%b exp=0", bus.i_rdata_valid);
        end
        @(negedge clk);  // cycle 4
        #1;
        checks++;
        if (bus.i_rdata_valid !== 1'b1 || bus.i_rdata !== 32'h3) begin
            failures++;
            $display("FAIL mid_reissue got valid=%b data=%h exp 1 3", bus.i_rdata_valid, bus.i_rdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_cmd_start   = 1'b0;
        bus.i_addr        = 32'h0;
        bus.d_cmd_start   = 1'b0;
        bus.d_cmd_write   = 1'b0;
        bus.d_addr        = 32'h0;
        bus.d_wdata       = 32'h0;
        bus.mem_cmd_ready = 1'b1;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
